// File: rtl/chamber_timer_display_if.sv
// Signal bundle between the airlock chamber timer/display block and its environment.
// The slave side is the timer; the master side drives commands and sensor status.
interface chamber_timer_display_if;
    logic       FillStart;
    logic       EvacStart;
    logic       ReqReject;
    logic       OuterClosed;
    logic       InnerClosed;
    logic       Pressurized;
    logic       Evacuated;
    logic       PressDone;
    logic       EvacDone;
    logic       Busy;
    logic [6:0] HEX5;
    logic [6:0] HEX4;
    logic [6:0] HEX3;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;

    modport slave (
        input  FillStart, EvacStart, ReqReject,
        input  OuterClosed, InnerClosed, Pressurized, Evacuated,
        output PressDone, EvacDone, Busy,
        output HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
    );

    modport master (
        output FillStart, EvacStart, ReqReject,
        output OuterClosed, InnerClosed, Pressurized, Evacuated,
        input  PressDone, EvacDone, Busy,
        input  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
    );
endinterface

// File: rtl/chamber_timer_display.sv
// Airlock chamber cycle timer: runs fill/evacuate/error countdowns in one-second ticks
// and drives a six-digit active-low seven-segment status display.
module chamber_timer_display #(
    parameter int TICK_CYCLES = 50000000,
    parameter int FP_SECS     = 7,
    parameter int EV_SECS     = 8,
    parameter int ERR_SECS    = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    chamber_timer_display_if.slave  bus
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    FP_LOAD  = 4'(FP_SECS);
    localparam logic [3:0]    EV_LOAD  = 4'(EV_SECS);
    localparam logic [3:0]    ERR_LOAD = 4'(ERR_SECS);

    localparam logic [6:0] G_A     = 7'h08;
    localparam logic [6:0] G_C     = 7'h46;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_F     = 7'h0E;
    localparam logic [6:0] G_I     = 7'h79;
    localparam logic [6:0] G_L     = 7'h47;
    localparam logic [6:0] G_P     = 7'h0C;
    localparam logic [6:0] G_R     = 7'h2F;
    localparam logic [6:0] G_S     = 7'h12;
    localparam logic [6:0] G_U     = 7'h41;
    localparam logic [6:0] G_O     = 7'h23;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EVAC = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    count_q, count_d;
    logic          press_done_q, press_done_d;
    logic          evac_done_q, evac_done_d;
    logic          disp_en_q, disp_en_d;
    logic [41:0]   disp_q, disp_d;
    logic          tick_s;
    logic          start_s;
    logic [3:0]    tens_s, units_s;

    // Countdown sequencing: IDLE arbitration, prescaler and remaining-count update.
    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        count_d      = count_q;
        press_done_d = 1'b0;
        evac_done_d  = 1'b0;
        tick_s       = (pre_q == PRE_MAX);
        start_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pre_d = {PW{1'b0}};
                if (bus.ReqReject || (bus.FillStart && bus.EvacStart)) begin
                    state_d = ST_ERR;
                    count_d = ERR_LOAD;
                    start_s = 1'b1;
                end else if (bus.FillStart) begin
                    state_d = ST_FILL;
                    count_d = FP_LOAD;
                    start_s = 1'b1;
                end else if (bus.EvacStart) begin
                    state_d = ST_EVAC;
                    count_d = EV_LOAD;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL, ST_EVAC, ST_ERR: begin
                if (tick_s) begin
                    pre_d = {PW{1'b0}};
                    // Treat 0 like 1 so a corrupted count can never wrap to 15.
                    if (count_q <= 4'd1) begin
                        state_d      = ST_IDLE;
                        count_d      = 4'd0;
                        press_done_d = (state_q == ST_FILL);
                        evac_done_d  = (state_q == ST_EVAC);
                    end else begin
                        count_d = count_q - 4'd1;
                    end
                end else begin
                    pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = {PW{1'b0}};
                count_d = 4'd0;
            end
        endcase
    end

    // Display message from the current state and count (registered one cycle later).
    always_comb begin
        disp_en_d = 1'b1;
        disp_d    = {6{G_BLANK}};
        tens_s    = (count_q >= 4'd10) ? 4'd1 : 4'd0;
        units_s   = (count_q >= 4'd10) ? (count_q - 4'd10) : count_q;
        if (!disp_en_q) begin
            disp_d = {6{G_BLANK}};
        end else begin
            case (state_q)
                ST_FILL: disp_d = {G_F, G_I, G_L, G_L, digit_seg(tens_s), digit_seg(units_s)};
                ST_EVAC: disp_d = {G_E, G_U, G_A, G_C, digit_seg(tens_s), digit_seg(units_s)};
                ST_ERR:  disp_d = {G_E, G_R, G_R, G_BLANK, G_BLANK, G_BLANK};
                ST_IDLE: begin
                    if (bus.Pressurized && !bus.Evacuated) begin
                        disp_d[41:14] = {G_P, G_R, G_E, G_S};
                    end else if (bus.Evacuated && !bus.Pressurized) begin
                        disp_d[41:14] = {G_E, G_U, G_A, G_C};
                    end else begin
                        disp_d[41:14] = {4{G_DASH}};
                    end
                    disp_d[13:7] = bus.OuterClosed ? G_C : G_O;
                    disp_d[6:0]  = bus.InnerClosed ? G_C : G_O;
                end
                default: disp_d = {6{G_BLANK}};
            endcase
        end
    end

    // State, timing and display registers; display is held blank during reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            pre_q        <= {PW{1'b0}};
            count_q      <= 4'd0;
            press_done_q <= 1'b0;
            evac_done_q  <= 1'b0;
            disp_en_q    <= 1'b0;
            disp_q       <= {6{G_BLANK}};
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            count_q      <= count_d;
            press_done_q <= press_done_d;
            evac_done_q  <= evac_done_d;
            disp_en_q    <= disp_en_d;
            disp_q       <= disp_d;
        end
    end

    assign bus.PressDone = press_done_q;
    assign bus.EvacDone  = evac_done_q;
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.HEX5      = disp_q[41:35];
    assign bus.HEX4      = disp_q[34:28];
    assign bus.HEX3      = disp_q[27:21];
    assign bus.HEX2      = disp_q[20:14];
    assign bus.HEX1      = disp_q[13:7];
    assign bus.HEX0      = disp_q[6:0];

endmodule

// File: tb/tb_chamber_timer_display.sv
// Directed bench for chamber_timer_display with TICK_CYCLES=4, FP=7, EV=8, ERR=2.
module tb_chamber_timer_display;

    logic Clock;
    logic Reset;
    int   total;
    int   bad;

    chamber_timer_display_if bus ();

    chamber_timer_display #(
        .TICK_CYCLES (4),
        .FP_SECS     (7),
        .EV_SECS     (8),
        .ERR_SECS    (2)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [6:0] dig(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] hex_all();
        return {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    endfunction

    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    localparam logic [41:0] ALL_BLANK  = {6{7'h7F}};
    localparam logic [41:0] IDLE_PRES  = {7'h0C, 7'h2F, 7'h06, 7'h12, 7'h46, 7'h23};
    localparam logic [41:0] IDLE_EVAC  = {7'h06, 7'h41, 7'h08, 7'h46, 7'h23, 7'h46};
    localparam logic [27:0] MSG_FILL   = {7'h0E, 7'h79, 7'h47, 7'h47};
    localparam logic [27:0] MSG_EUAC   = {7'h06, 7'h41, 7'h08, 7'h46};
    localparam logic [41:0] MSG_ERR    = {7'h06, 7'h2F, 7'h2F, 7'h7F, 7'h7F, 7'h7F};

    initial begin
        int n;
        total = 0;
        bad   = 0;
        bus.FillStart   = 1'b0;
        bus.EvacStart   = 1'b0;
        bus.ReqReject   = 1'b0;
        bus.OuterClosed = 1'b0;
        bus.InnerClosed = 1'b0;
        bus.Pressurized = 1'b0;
        bus.Evacuated   = 1'b0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        chk("rst_hex", hex_all(), ALL_BLANK);
        chk("rst_busy", 42'(bus.Busy), 42'd0);
        chk("rst_pdone", 42'(bus.PressDone), 42'd0);
        chk("rst_edone", 42'(bus.EvacDone), 42'd0);
        step();
        step();
        chk("rst_hold_hex", hex_all(), ALL_BLANK);

        // Release reset; IDLE display must appear on the second edge.
        bus.OuterClosed = 1'b1;
        bus.InnerClosed = 1'b0;
        bus.Pressurized = 1'b1;
        Reset = 1'b1;
        step();
        chk("rel_edge1_hex", hex_all(), ALL_BLANK);
        step();
        chk("rel_edge2_hex", hex_all(), IDLE_PRES);

        // Fill countdown with ignored EvacStart, ReqReject and a start on the final tick.
        bus.FillStart = 1'b1;
        step();
        bus.FillStart = 1'b0;
        for (int c = 0; c <= 29; c++) begin
            chk($sformatf("fill_pdone_c%0d", c), 42'(bus.PressDone), 42'(c == 28));
            chk($sformatf("fill_edone_c%0d", c), 42'(bus.EvacDone), 42'd0);
            chk($sformatf("fill_busy_c%0d", c), 42'(bus.Busy), 42'(c < 28));
            if (c >= 1 && c <= 28) begin
                n = 7 - (c - 1) / 4;
                chk($sformatf("fill_hex_c%0d", c), hex_all(), {MSG_FILL, dig(n / 10), dig(n % 10)});
            end
            if (c == 29) chk("fill_idle_hex", hex_all(), IDLE_PRES);
            bus.EvacStart = (c == 10);
            bus.ReqReject = (c == 15);
            bus.FillStart = (c == 27);
            step();
            bus.EvacStart = 1'b0;
            bus.ReqReject = 1'b0;
            bus.FillStart = 1'b0;
        end

        // Evacuate countdown.
        bus.Pressurized = 1'b0;
        bus.Evacuated   = 1'b1;
        bus.OuterClosed = 1'b0;
        bus.InnerClosed = 1'b1;
        bus.EvacStart   = 1'b1;
        step();
        bus.EvacStart = 1'b0;
        for (int c = 0; c <= 33; c++) begin
            chk($sformatf("evac_edone_c%0d", c), 42'(bus.EvacDone), 42'(c == 32));
            chk($sformatf("evac_pdone_c%0d", c), 42'(bus.PressDone), 42'd0);
            chk($sformatf("evac_busy_c%0d", c), 42'(bus.Busy), 42'(c < 32));
            if (c >= 1 && c <= 32) begin
                n = 8 - (c - 1) / 4;
                chk($sformatf("evac_hex_c%0d", c), hex_all(), {MSG_EUAC, dig(n / 10), dig(n % 10)});
            end
            if (c == 33) chk("evac_idle_hex", hex_all(), IDLE_EVAC);
            step();
        end

        // Simultaneous starts go to ERR for 2 ticks with no Done pulse.
        bus.FillStart = 1'b1;
        bus.EvacStart = 1'b1;
        step();
        bus.FillStart = 1'b0;
        bus.EvacStart = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            chk($sformatf("err_busy_c%0d", c), 42'(bus.Busy), 42'(c < 8));
            chk($sformatf("err_done_c%0d", c), {40'd0, bus.PressDone, bus.EvacDone}, 42'd0);
            if (c >= 1 && c <= 8) chk($sformatf("err_hex_c%0d", c), hex_all(), MSG_ERR);
            if (c == 9) chk("err_idle_hex", hex_all(), IDLE_EVAC);
            step();
        end

        // ReqReject wins over FillStart.
        bus.ReqReject = 1'b1;
        bus.FillStart = 1'b1;
        step();
        bus.ReqReject = 1'b0;
        bus.FillStart = 1'b0;
        step();
        chk("rej_hex", hex_all(), MSG_ERR);
        for (int c = 2; c < 9; c++) step();
        chk("rej_idle_busy", 42'(bus.Busy), 42'd0);

        // Reset mid-FILL aborts without PressDone.
        bus.FillStart = 1'b1;
        step();
        bus.FillStart = 1'b0;
        for (int c = 0; c < 12; c++) step();
        chk("abort_busy_pre", 42'(bus.Busy), 42'd1);
        Reset = 1'b0;
        #1;
        chk("abort_hex", hex_all(), ALL_BLANK);
        chk("abort_busy", 42'(bus.Busy), 42'd0);
        step();
        step();
        Reset = 1'b1;
        step();
        chk("abort_rel1_hex", hex_all(), ALL_BLANK);
        step();
        chk("abort_rel2_hex", hex_all(), IDLE_EVAC);
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("abort_pdone_c%0d", c), 42'(bus.PressDone), 42'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
